dmem_bridge: RTL
================

Name: dmem_bridge

Overview:
- Sits directly downstream of the single-cycle core's data port. Replaces the ideal zero-latency data memory with a variable-latency req/ack bus.
- Converts core load/store requests into word-aligned bus transactions. Generates byte enables and store-data lane replication, and sign/zero-extends loads.
- Holds the core with stall_o until each access completes.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles bus_req_o stays high without bus_ack_i before the access is aborted.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- core_ce_i  input  1  core data access request, level, held until stall_o low.
- core_we_i  input  1  1 = store, 0 = load.
- core_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
- core_unsigned_i  input  1  load zero-extend (LBU/LHU) when 1.
- core_addr_i  input  32  byte address.
- core_wdata_i  input  32  store data, right-aligned.
- core_rdata_o  output  32  extended load result; valid in the cycle stall_o drops.
- stall_o  output  1  freezes core PC/writeback while high.
- misalign_o  output  1  one-cycle pulse on misaligned/illegal access.
- bus_err_o  output  1  one-cycle pulse on timeout.
- bus_req_o  output  1  bus request, held until ack.
- bus_we_o  output  1  bus write.
- bus_addr_o  output  32  word address, bits [1:0] forced 0.
- bus_be_o  output  4  byte enables; all 1s on reads.
- bus_wdata_o  output  32  lane-replicated store data.
- bus_ack_i  input  1  completion, single-cycle pulse.
- bus_rdata_i  input  32  read word, valid with bus_ack_i.

Behaviour:
- Reset (rst=0, asynchronous) forces the following immediately:
  - state IDLE; all outputs 0; counter 0; latched request registers 0.
  - An in-flight bus_req_o drops at once. A later bus_ack_i for it is ignored.
- FSM states: IDLE, REQ, DONE, ERR. All outputs except stall_o are registered.
- stall_o = core_ce_i & (state != DONE) & (state != ERR) & ~misalign_now. This is combinational.
- misalign_now is true in IDLE with core_ce_i=1 when any of:
  - size=11;
  - size=01 and addr[0]=1;
  - size=10 and addr[1:0]!=0.
- IDLE with misalign_now:
  - No bus transaction; stays IDLE; stall_o low.
  - misalign_o pulses the next cycle.
  - core_rdata_o is 0; the store is suppressed.
- IDLE with core_ce_i and aligned:
  - Latch we, size, unsigned, addr[1:0], be, wdata; go to REQ.
- REQ:
  - bus_req_o=1 and the bus_* fields stay stable until bus_ack_i.
  - On ack, latch the extended rdata and go to DONE.
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES with no ack, go to ERR.
- DONE:
  - stall_o=0 and core_rdata_o valid (0 for stores).
  - Returns to IDLE next cycle unconditionally. A back-to-back access is therefore seen in IDLE the next cycle.
- ERR:
  - bus_err_o=1 and stall_o=0; core_rdata_o=0; bus_req_o=0.
  - Returns to IDLE next cycle.
  - A late ack arriving in ERR/IDLE/DONE is ignored.
- Minimum latency: request cycle (IDLE) + 1 REQ cycle with ack + DONE. stall_o is high for 2 cycles at zero wait states.
- Byte enables and store data:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - word: be = 1111; wdata passed through.
- Load extraction:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - Sign-extend from bit 7/15 unless unsigned; word passed through.
- Counter clears on entry to REQ.

Decomposition:
- Package riscv_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state encoding.
  - default TIMEOUT constant.
- One combinational sub-module, dmem_lane_align: be generation, store replication, load extraction/extension, misalign detect. It is reused by the bridge and by the verification reference model.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ack in first REQ cycle -> bus_addr 0x100, be 1111, wdata 0xDEADBEEF, stall high exactly 2 cycles.
- LB addr 0x203, bus_rdata 0x80112233, ack after 3 wait cycles -> core_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x302, wdata 0x0000A5C3 -> be 1100, wdata 0xA5C3A5C3. LH addr 0x301 -> misalign_o pulse, no bus_req, rdata 0.
- LW with ack never asserted, TIMEOUT_CYCLES=4 -> bus_req high 4 cycles, bus_err_o pulse, stall drops, rdata 0. A late ack 2 cycles after ERR is ignored.
- rst low mid-REQ -> bus_req_o and stall-related state clear immediately. After release, a new LW completes normally.
- Back-to-back LW 0x0, SW 0x4, each with zero wait -> two complete transactions, a single DONE cycle between them, no dropped or duplicated bus_req.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory bridge: access sizes, FSM states and the default bus timeout.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    localparam int         TIMEOUT_DEFAULT = 255;
    localparam logic [3:0] BE_ALL          = 4'b1111;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data port: byte enables, store replication,
// load extraction with sign/zero extension, and alignment checking.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = rdata;
        misalign  = 1'b0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                misalign  = addr_lo[0];
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            end
            SZ_WORD: begin
                misalign  = |addr_lo;
                be        = BE_ALL;
            end
            default: begin
                misalign  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the single-cycle core's data port onto a variable-latency req/ack bus,
// stalling the core until each access completes, aborts on timeout or misalignment.
module dmem_bridge
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 8
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        core_ce_i,
    input  logic        core_we_i,
    input  logic [1:0]  core_size_i,
    input  logic        core_unsigned_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             req_we, req_unsigned;
    logic [1:0]       req_size, req_addr_lo;

    logic             in_idle, in_req, start, misalign_now, timeout_hit;
    logic [1:0]       al_size, al_addr_lo;
    logic             al_unsigned, al_misalign;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata, al_rdata_ext;

    assign in_idle = (state == ST_IDLE);
    assign in_req  = (state == ST_REQ);

    // In IDLE the aligner sees the live core request; afterwards it decodes the latched one.
    assign al_size     = in_idle ? core_size_i       : req_size;
    assign al_addr_lo  = in_idle ? core_addr_i[1:0]  : req_addr_lo;
    assign al_unsigned = in_idle ? core_unsigned_i   : req_unsigned;

    dmem_lane_align u_align (
        .size        (al_size),
        .is_unsigned (al_unsigned),
        .addr_lo     (al_addr_lo),
        .wdata       (core_wdata_i),
        .rdata       (bus_rdata_i),
        .be          (al_be),
        .wdata_rep   (al_wdata),
        .rdata_ext   (al_rdata_ext),
        .misalign    (al_misalign)
    );

    assign misalign_now = in_idle & core_ce_i & al_misalign;
    assign start        = in_idle & core_ce_i & ~al_misalign;
    assign cnt_inc      = cnt + CNT_W'(1);
    assign timeout_hit  = (cnt_inc == TIMEOUT_LIM);

    assign stall_o = core_ce_i & (state != ST_DONE) & (state != ST_ERR) & ~misalign_now;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_REQ;
            ST_REQ: begin
                if (bus_ack_i)        state_nxt = ST_DONE;
                else if (timeout_hit) state_nxt = ST_ERR;
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            req_we       <= 1'b0;
            req_unsigned <= 1'b0;
            req_size     <= 2'b00;
            req_addr_lo  <= 2'b00;
            core_rdata_o <= '0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_be_o     <= 4'b0000;
            bus_wdata_o  <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            state      <= state_nxt;
            misalign_o <= misalign_now;
            bus_err_o  <= in_req & ~bus_ack_i & timeout_hit;
            // Load data is held only for the DONE cycle; everything else reads back as zero.
            core_rdata_o <= (in_req & bus_ack_i & ~req_we) ? al_rdata_ext : '0;

            if (start) begin
                req_we       <= core_we_i;
                req_unsigned <= core_unsigned_i;
                req_size     <= core_size_i;
                req_addr_lo  <= core_addr_i[1:0];
                cnt          <= '0;
                bus_req_o    <= 1'b1;
                bus_we_o     <= core_we_i;
                bus_addr_o   <= {core_addr_i[31:2], 2'b00};
                bus_be_o     <= core_we_i ? al_be : BE_ALL;
                bus_wdata_o  <= al_wdata;
            end

            if (in_req) begin
                if (bus_ack_i || timeout_hit) bus_req_o <= 1'b0;
                if (!bus_ack_i)               cnt       <= cnt_inc;
            end
        end
    end

endmodule
